rangedecode: RTL
================

RANGEDECODE -- requirements
Module: rangedecode

Interface
REQ-001 SHALL have parameter NS, default 4: number of slaves.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 38: sideband data width.
REQ-004 SHALL have parameter SLAVE_BASE [NS*AW-1:0]: inclusive lower address of slave k in bits [k*AW +: AW].
REQ-005 SHALL have parameter SLAVE_LAST [NS*AW-1:0]: inclusive upper address of slave k.
REQ-006 SHALL have parameter ACCESS_ALLOWED [NS-1:0], default all ones: per-slave access enable.
REQ-007 SHALL have parameter OPT_LOWPOWER, default 0: zero the data outputs while o_valid is low.
REQ-008 SHALL have parameter CW, default 16: miss-counter width.
REQ-009 i_clk  input  1  clock.
REQ-010 i_reset  input  1  reset, synchronous, active-high.
REQ-011 i_valid  input  1  request valid.
REQ-012 o_stall  output  1  input not accepted (registered).
REQ-013 i_addr  input  AW  request address.
REQ-014 i_data  input  DW  request sideband.
REQ-015 o_valid  output  1  decoded request valid.
REQ-016 i_stall  input  1  downstream back-pressure.
REQ-017 o_decode  output  NS+1  one-hot slave select; bit NS means no slave matched.
REQ-018 o_addr  output  AW  registered address.
REQ-019 o_data  output  DW  registered sideband.
REQ-020 o_miss_count  output  CW  saturating count of no-slave transfers.

Function
REQ-021 A request SHALL be accepted in any cycle where i_valid && !o_stall.
REQ-022 An output transfer SHALL occur in any cycle where o_valid && !i_stall.
REQ-023 hit[k] SHALL be ACCESS_ALLOWED[k] && SLAVE_BASE[k] <= i_addr <= SLAVE_LAST[k], using unsigned AW-bit compares.
REQ-024 When ranges overlap, the lowest-index hit SHALL win, so o_decode is always one-hot.
REQ-025 When no hit exists, o_decode[NS] SHALL be set.
REQ-026 o_decode SHALL be nonzero exactly when o_valid is high.
REQ-027 Latency SHALL be one cycle from acceptance to o_valid, with throughput of one request per cycle.
REQ-028 The output register SHALL load the accepted request, or the skid entry, whenever !o_valid || !i_stall.
REQ-029 While o_valid && i_stall, o_addr, o_data and o_decode SHALL hold stable.
REQ-030 Skid buffer: if a request is accepted while the output is held, it SHALL be stored in a one-entry skid register.
REQ-031 o_stall SHALL be registered, equal to skid-full, and SHALL NOT depend combinationally on i_stall.
REQ-032 When the output frees and the skid is full, the skid entry SHALL move to the output and o_stall SHALL fall on the next cycle.
REQ-033 Ordering SHALL be preserved, and no request SHALL be lost or duplicated.
REQ-034 Decoding SHALL happen at input, and the skid register SHALL store the decoded one-hot.
REQ-035 With OPT_LOWPOWER=1, o_addr, o_data and o_decode SHALL be zero whenever o_valid is low, and the skid contents SHALL be zero when the skid is empty.
REQ-036 o_miss_count SHALL increment on each output transfer with o_decode[NS] set, and SHALL saturate at 2^CW-1.

Reset
REQ-037 On i_reset, o_valid, o_stall, o_decode, the skid-full flag and o_miss_count SHALL all be set to 0.
REQ-038 With OPT_LOWPOWER=1, o_addr and o_data SHALL also be set to 0 on reset.
REQ-039 Reset mid-operation SHALL discard both the output entry and the skid entry, with no transfer in the following cycle.

Structure
REQ-040 Shared package rangedecode_pkg SHALL hold the one-hot/none-select index helper and the default base/last constants.
REQ-041 The combinational priority match SHALL be a sub-module rangedecode_match (inputs: address; output: NS+1 one-hot), instantiated once.

Verification
All scenarios use NS=3, AW=16, DW=8, ranges 0x0000-0x0FFF, 0x1000-0x1FFF and 0x1800-0x2FFF, ACCESS_ALLOWED=3'b011, CW=2.
REQ-042 addr 0x0800 valid one cycle, i_stall=0 -> next cycle o_valid=1, o_decode=4'b0001, o_addr=0x0800.
REQ-043 addr 0x1900 (slave 1/2 overlap) -> o_decode=4'b0010.
REQ-044 addr 0x2800 (slave 2 disallowed) -> o_decode=4'b1000, then o_miss_count=1 after the transfer.
REQ-045 Requests A, B, C on consecutive cycles with i_stall=1 on cycles 2-3 -> o_stall=1 on cycles 3-4, and A, B, C emerge in order with none lost.
REQ-046 Reset asserted with the skid full -> next cycle o_valid=0, o_stall=0, o_decode=0, o_miss_count=0.
REQ-047 Five consecutive miss transfers -> o_miss_count saturates at 3.

Source files
------------

// File: rtl/rangedecode_pkg.sv
// Shared constants and helpers for the address range decoder.
// Holds the default slave map and the index of the "no slave matched" select bit.
package rangedecode_pkg;

    localparam int unsigned DEF_NS = 4;
    localparam int unsigned DEF_AW = 32;

    // Default map: four 256 MiB windows at the bottom of the address space.
    localparam logic [DEF_NS*DEF_AW-1:0] DEF_SLAVE_BASE = {
        32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    };
    localparam logic [DEF_NS*DEF_AW-1:0] DEF_SLAVE_LAST = {
        32'h3FFF_FFFF, 32'h2FFF_FFFF, 32'h1FFF_FFFF, 32'h0FFF_FFFF
    };

    // The decode vector carries one bit per slave plus a trailing "none" bit.
    function automatic int unsigned none_sel_idx(input int unsigned ns);
        return ns;
    endfunction

endpackage

// File: rtl/rangedecode_match.sv
// Combinational priority range match: one-hot select of the lowest-index
// enabled slave whose [base, last] window contains the address, else "none".
module rangedecode_match import rangedecode_pkg::*; #(
    parameter int unsigned         NS             = DEF_NS,
    parameter int unsigned         AW             = DEF_AW,
    parameter logic [NS*AW-1:0]    SLAVE_BASE     = DEF_SLAVE_BASE,
    parameter logic [NS*AW-1:0]    SLAVE_LAST     = DEF_SLAVE_LAST,
    parameter logic [NS-1:0]       ACCESS_ALLOWED = '1
) (
    input  logic [AW-1:0] i_addr,
    output logic [NS:0]   o_decode
);

    localparam int unsigned NONE = none_sel_idx(NS);

    logic [NS-1:0] w_hit;
    logic          w_found;

    always_comb begin
        w_hit = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            w_hit[k] = ACCESS_ALLOWED[k]
                     && (i_addr >= SLAVE_BASE[k*AW +: AW])
                     && (i_addr <= SLAVE_LAST[k*AW +: AW]);
        end
    end

    // Lowest index wins, so overlapping windows still give a one-hot result.
    always_comb begin
        o_decode = '0;
        w_found  = 1'b0;
        for (int unsigned k = 0; k < NS; k++) begin
            if (!w_found && w_hit[k]) begin
                o_decode[k] = 1'b1;
                w_found     = 1'b1;
            end
        end
        o_decode[NONE] = !w_found;
    end

endmodule

// File: rtl/rangedecode.sv
// Registered address range decoder with a one-entry skid buffer so that the
// upstream stall is registered, plus a saturating count of unmatched transfers.
module rangedecode import rangedecode_pkg::*; #(
    parameter int unsigned         NS             = DEF_NS,
    parameter int unsigned         AW             = DEF_AW,
    parameter int unsigned         DW             = 38,
    parameter logic [NS*AW-1:0]    SLAVE_BASE     = DEF_SLAVE_BASE,
    parameter logic [NS*AW-1:0]    SLAVE_LAST     = DEF_SLAVE_LAST,
    parameter logic [NS-1:0]       ACCESS_ALLOWED = '1,
    parameter bit                  OPT_LOWPOWER   = 1'b0,
    parameter int unsigned         CW             = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_stall,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_stall,
    output logic [NS:0]   o_decode,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_miss_count
);

    localparam int unsigned NONE = none_sel_idx(NS);

    logic [NS:0]   w_in_decode;
    logic          w_accept;
    logic          w_out_ready;
    logic          w_miss_xfer;

    logic          r_valid;
    logic [NS:0]   r_decode;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    logic          r_skid_full;
    logic [NS:0]   r_skid_decode;
    logic [AW-1:0] r_skid_addr;
    logic [DW-1:0] r_skid_data;

    logic [CW-1:0] r_miss_count;

    rangedecode_match #(
        .NS             (NS),
        .AW             (AW),
        .SLAVE_BASE     (SLAVE_BASE),
        .SLAVE_LAST     (SLAVE_LAST),
        .ACCESS_ALLOWED (ACCESS_ALLOWED)
    ) u_match (
        .i_addr   (i_addr),
        .o_decode (w_in_decode)
    );

    always_comb begin
        w_accept    = i_valid && !r_skid_full;
        w_out_ready = !r_valid || !i_stall;
        w_miss_xfer = r_valid && !i_stall && r_decode[NONE];
    end

    // Output stage: the skid entry is older than anything on the input, so it
    // takes priority; while the skid is full the input is stalled anyway.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid  <= 1'b0;
            r_decode <= '0;
            if (OPT_LOWPOWER) begin
                r_addr <= '0;
                r_data <= '0;
            end
        end else if (w_out_ready) begin
            if (r_skid_full) begin
                r_valid  <= 1'b1;
                r_decode <= r_skid_decode;
                r_addr   <= r_skid_addr;
                r_data   <= r_skid_data;
            end else if (w_accept) begin
                r_valid  <= 1'b1;
                r_decode <= w_in_decode;
                r_addr   <= i_addr;
                r_data   <= i_data;
            end else begin
                r_valid  <= 1'b0;
                r_decode <= '0;
                if (OPT_LOWPOWER) begin
                    r_addr <= '0;
                    r_data <= '0;
                end
            end
        end
    end

    // Skid stage: captures a request accepted while the output is held.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_skid_full   <= 1'b0;
            r_skid_decode <= '0;
            if (OPT_LOWPOWER) begin
                r_skid_addr <= '0;
                r_skid_data <= '0;
            end
        end else if (r_skid_full && w_out_ready) begin
            r_skid_full <= 1'b0;
            if (OPT_LOWPOWER) begin
                r_skid_decode <= '0;
                r_skid_addr   <= '0;
                r_skid_data   <= '0;
            end
        end else if (w_accept && !w_out_ready) begin
            r_skid_full   <= 1'b1;
            r_skid_decode <= w_in_decode;
            r_skid_addr   <= i_addr;
            r_skid_data   <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_miss_count <= '0;
        end else if (w_miss_xfer && (r_miss_count != '1)) begin
            r_miss_count <= r_miss_count + 1'b1;
        end
    end

    always_comb begin
        o_stall      = r_skid_full;
        o_valid      = r_valid;
        o_decode     = r_decode;
        o_addr       = r_addr;
        o_data       = r_data;
        o_miss_count = r_miss_count;
    end

endmodule
